// File: rtl/coproc_pkg.sv
// Shared definitions for the zoom coprocessor command issuer: opcodes,
// response flag bit positions and the issuer state encoding.
package coproc_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_STORE      = 3'd2;
    localparam logic [2:0] OP_ZIN_VP     = 3'd3;
    localparam logic [2:0] OP_ZIN_RP     = 3'd4;
    localparam logic [2:0] OP_ZOUT_MP    = 3'd5;
    localparam logic [2:0] OP_ZOUT_VD    = 3'd6;
    localparam logic [2:0] OP_RESET_INST = 3'd7;

    // Bit positions inside rsp_flags = {timeout, zoom_min, zoom_max, error}
    localparam int FLAG_ERROR_BIT    = 0;
    localparam int FLAG_ZOOM_MAX_BIT = 1;
    localparam int FLAG_ZOOM_MIN_BIT = 2;
    localparam int FLAG_TIMEOUT_BIT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RESPOND
    } issuer_state_t;

    // NOP and RESET_INST never drop FLAG_DONE, so they use a fixed settle wait.
    function automatic logic is_fixed_wait(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_RESET_INST);
    endfunction

endpackage

// File: rtl/flag_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous coprocessor flags.
// The reset value is a parameter so FLAG_DONE can come out of reset as "idle".
module flag_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_100,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the async input through the synchronizer chain
    always_ff @(posedge clk_100) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/coproc_cmd_issuer.sv
// Host-side initiator for the zoom coprocessor command port. Takes one
// command per handshake, strobes the active-low ENABLE, follows FLAG_DONE
// through its drop and recovery, and returns exactly one response.
module coproc_cmd_issuer
    import coproc_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 64,
    parameter int unsigned DONE_TIMEOUT  = 2000000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_instr,
    input  logic [7:0]  cmd_data,
    input  logic [16:0] cmd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [3:0]  rsp_flags,
    output logic [2:0]  INSTRUCTION,
    output logic [7:0]  DATA_IN,
    output logic [16:0] MEM_ADDR,
    output logic        ENABLE,
    input  logic        FLAG_DONE,
    input  logic        FLAG_ERROR,
    input  logic        FLAG_ZOOM_MAX,
    input  logic        FLAG_ZOOM_MIN,
    input  logic [7:0]  DATA_OUT
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] DONE_LAST   = CW'(DONE_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    issuer_state_t state, state_next;
    logic [CW-1:0] cnt;
    logic          ack_seen;
    logic          done_s, error_s, zmax_s, zmin_s;
    logic          load_rsp;
    logic [7:0]    rsp_data_d;
    logic [3:0]    rsp_flags_d;

    flag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_done (
        .clk_100(clk_100), .reset(reset), .d(FLAG_DONE), .q(done_s)
    );
    flag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_error (
        .clk_100(clk_100), .reset(reset), .d(FLAG_ERROR), .q(error_s)
    );
    flag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_zmax (
        .clk_100(clk_100), .reset(reset), .d(FLAG_ZOOM_MAX), .q(zmax_s)
    );
    flag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_zmin (
        .clk_100(clk_100), .reset(reset), .d(FLAG_ZOOM_MIN), .q(zmin_s)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESPOND);

    // Next-state decode and the response payload latched on entry to RESPOND
    always_comb begin
        state_next  = state;
        load_rsp    = 1'b0;
        rsp_data_d  = '0;
        rsp_flags_d = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST)
                    state_next = is_fixed_wait(INSTRUCTION) ? ST_SETTLE : ST_WAIT_ACK;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = ST_RESPOND;
                    load_rsp   = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (!done_s || ack_seen) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt == ACK_LAST) begin
                    state_next = ST_RESPOND;
                    load_rsp   = 1'b1;
                    rsp_flags_d[FLAG_TIMEOUT_BIT] = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (done_s) begin
                    state_next = ST_RESPOND;
                    load_rsp   = 1'b1;
                    rsp_data_d = (INSTRUCTION == OP_LOAD) ? DATA_OUT : 8'h00;
                    rsp_flags_d[FLAG_ERROR_BIT]    = error_s;
                    rsp_flags_d[FLAG_ZOOM_MAX_BIT] = zmax_s;
                    rsp_flags_d[FLAG_ZOOM_MIN_BIT] = zmin_s;
                end else if (cnt == DONE_LAST) begin
                    state_next = ST_RESPOND;
                    load_rsp   = 1'b1;
                    rsp_flags_d[FLAG_TIMEOUT_BIT] = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus the shared saturating counter, cleared on each state entry
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
        end
    end

    // Remember an ack (FLAG_DONE drop) that arrives while ENABLE is still low
    always_ff @(posedge clk_100) begin
        if (reset)
            ack_seen <= 1'b0;
        else if (state == ST_IDLE)
            ack_seen <= 1'b0;
        else if (state == ST_PULSE && !done_s)
            ack_seen <= 1'b1;
    end

    // Coprocessor operands: captured on accept and frozen until the next accept;
    // ENABLE is registered so it is low exactly while the FSM sits in PULSE
    always_ff @(posedge clk_100) begin
        if (reset) begin
            INSTRUCTION <= '0;
            DATA_IN     <= '0;
            MEM_ADDR    <= '0;
            ENABLE      <= 1'b1;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                INSTRUCTION <= cmd_instr;
                DATA_IN     <= cmd_data;
                MEM_ADDR    <= cmd_addr;
            end
            ENABLE <= (state_next != ST_PULSE);
        end
    end

    // Response fields, held stable through RESPOND until the next response
    always_ff @(posedge clk_100) begin
        if (reset) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (load_rsp) begin
            rsp_data  <= rsp_data_d;
            rsp_flags <= rsp_flags_d;
        end
    end

endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Self-checking bench for coproc_cmd_issuer: a behavioural coprocessor model
// reacts to ENABLE, a monitor measures the strobe, and each scenario task
// compares the response against values derived from the command rules.
module tb_coproc_cmd_issuer;

    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_instr = '0;
    logic [7:0]  cmd_data = '0;
    logic [16:0] cmd_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_flags;
    logic [2:0]  INSTRUCTION;
    logic [7:0]  DATA_IN;
    logic [16:0] MEM_ADDR;
    logic        ENABLE;
    logic        FLAG_DONE = 1'b1;
    logic        FLAG_ERROR = 1'b0;
    logic        FLAG_ZOOM_MAX = 1'b0;
    logic        FLAG_ZOOM_MIN = 1'b0;
    logic [7:0]  DATA_OUT = '0;

    int n_tests = 0;
    int n_fail  = 0;

    coproc_cmd_issuer dut (
        .clk_100(clk_100), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_data(cmd_data), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .INSTRUCTION(INSTRUCTION), .DATA_IN(DATA_IN), .MEM_ADDR(MEM_ADDR),
        .ENABLE(ENABLE),
        .FLAG_DONE(FLAG_DONE), .FLAG_ERROR(FLAG_ERROR),
        .FLAG_ZOOM_MAX(FLAG_ZOOM_MAX), .FLAG_ZOOM_MIN(FLAG_ZOOM_MIN),
        .DATA_OUT(DATA_OUT)
    );

    always #5 clk_100 = ~clk_100;

    // ---------------- monitor: strobe shape, operands at the strobe, timing
    int          cyc = 0, low_cnt = 0, pulses = 0, t_rise = 0, t_rsp = 0;
    logic        en_prev = 1'b1, rv_prev = 1'b0;
    logic [2:0]  p_instr = '0;
    logic [7:0]  p_data = '0;
    logic [16:0] p_addr = '0;

    always @(negedge clk_100) begin
        cyc = cyc + 1;
        if (!ENABLE) low_cnt = low_cnt + 1;
        if (en_prev && !ENABLE) begin
            pulses  = pulses + 1;
            p_instr = INSTRUCTION;
            p_data  = DATA_IN;
            p_addr  = MEM_ADDR;
        end
        if (!en_prev && ENABLE) t_rise = cyc;
        if (rsp_valid && !rv_prev) t_rsp = cyc;
        en_prev = ENABLE;
        rv_prev = rsp_valid;
    end

    // ---------------- coprocessor model
    bit         m_drop = 1'b0;   // drop FLAG_DONE after the strobe at all?
    int         m_delay = 3;     // cycles from ENABLE rise to the drop
    int         m_busy = 10;     // cycles FLAG_DONE stays low
    logic [7:0] m_dout = '0;
    logic [2:0] m_flags = '0;    // {zoom_min, zoom_max, error} presented at done
    int         m_phase = 0, m_cnt = 0;

    always @(negedge clk_100) begin
        case (m_phase)
            0: if (!ENABLE) m_phase = 1;
            1: if (ENABLE) begin
                   if (m_drop) begin m_cnt = m_delay; m_phase = 2; end
                   else m_phase = 0;
               end
            2: if (m_cnt <= 1) begin
                   FLAG_DONE = 1'b0; m_cnt = m_busy; m_phase = 3;
               end else m_cnt = m_cnt - 1;
            3: if (m_cnt <= 1) begin
                   FLAG_DONE     = 1'b1;
                   DATA_OUT      = m_dout;
                   FLAG_ZOOM_MIN = m_flags[2];
                   FLAG_ZOOM_MAX = m_flags[1];
                   FLAG_ERROR    = m_flags[0];
                   m_phase = 0;
               end else m_cnt = m_cnt - 1;
            default: m_phase = 0;
        endcase
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(negedge clk_100);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [16:0] a,
                        output bit acc);
        int k;
        k = 0; acc = 1'b0;
        cmd_instr = op; cmd_data = d; cmd_addr = a; cmd_valid = 1'b1;
        while (!acc && k < 50) begin
            acc = cmd_ready;
            step();
            k++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic await_rsp(input int bound, output bit ok, output int busy_ready);
        int k;
        k = 0; busy_ready = 0;
        while (!rsp_valid && k < bound) begin
            if (cmd_ready) busy_ready++;
            step();
            k++;
        end
        ok = rsp_valid;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_flags} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_host_side: got rdy=%b rv=%b d=%h f=%b want 1 0 00 0000",
                     cmd_ready, rsp_valid, rsp_data, rsp_flags);
        end
        n_tests++;
        if ({INSTRUCTION, DATA_IN, MEM_ADDR, ENABLE} !== {3'd0, 8'h00, 17'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_copro_side: got i=%0d d=%h a=%h en=%b want 0 00 0 1",
                     INSTRUCTION, DATA_IN, MEM_ADDR, ENABLE);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_store();
        bit acc, ok; int br, bp, bl;
        m_drop = 1; m_delay = 3; m_busy = 10; m_dout = 8'h77; m_flags = 3'b000;
        bp = pulses; bl = low_cnt;
        send(3'd2, 8'hA5, 17'h00010, acc);
        await_rsp(200, ok, br);
        n_tests++;
        if (!acc || !ok) begin n_fail++; $display("FAIL store_handshake: acc=%b rsp=%b want 1 1", acc, ok); end
        n_tests++;
        if (pulses - bp != 1 || low_cnt - bl != 4) begin
            n_fail++; $display("FAIL store_pulse: pulses=%0d low=%0d want 1 4", pulses - bp, low_cnt - bl);
        end
        n_tests++;
        if ({p_instr, p_data, p_addr} !== {3'd2, 8'hA5, 17'h00010}) begin
            n_fail++; $display("FAIL store_operands: got %0d %h %h want 2 a5 00010", p_instr, p_data, p_addr);
        end
        n_tests++;
        if (rsp_flags !== 4'b0000 || rsp_data !== 8'h00) begin
            n_fail++; $display("FAIL store_rsp: flags=%b data=%h want 0000 00", rsp_flags, rsp_data);
        end
        release_rsp();
    endtask

    task automatic test_load();
        bit acc, ok; int br;
        m_drop = 1; m_delay = 2; m_busy = 6; m_dout = 8'h3C; m_flags = 3'b000;
        send(3'd1, 8'h00, 17'd76799, acc);
        await_rsp(200, ok, br);
        n_tests++;
        if (!acc || !ok || br != 0) begin
            n_fail++; $display("FAIL load_busy: acc=%b rsp=%b ready_while_busy=%0d want 1 1 0", acc, ok, br);
        end
        n_tests++;
        if (rsp_data !== 8'h3C || rsp_flags !== 4'b0000) begin
            n_fail++; $display("FAIL load_data: data=%h flags=%b want 3c 0000", rsp_data, rsp_flags);
        end
        n_tests++;
        if (p_addr !== 17'd76799) begin
            n_fail++; $display("FAIL load_addr: got %0d want 76799", p_addr);
        end
        repeat (3) step();
        n_tests++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL load_hold: rdy=%b rv=%b want 0 1", cmd_ready, rsp_valid);
        end
        release_rsp();
        n_tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_release: rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_inst();
        bit acc, ok; int br;
        m_drop = 0;
        send(3'd7, 8'h00, 17'd0, acc);
        await_rsp(200, ok, br);
        n_tests++;
        if (!ok || t_rsp - t_rise != 8) begin
            n_fail++; $display("FAIL reset_inst_latency: rsp=%b cycles=%0d want 1 8", ok, t_rsp - t_rise);
        end
        n_tests++;
        if (rsp_flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_inst_flags: got %b want 0000", rsp_flags);
        end
        release_rsp();
    endtask

    task automatic test_ack_timeout();
        bit acc, ok; int br;
        m_drop = 0;
        send(3'd3, 8'h11, 17'd5, acc);
        await_rsp(300, ok, br);
        n_tests++;
        if (!ok || t_rsp - t_rise != 64) begin
            n_fail++; $display("FAIL ack_timeout_latency: rsp=%b cycles=%0d want 1 64", ok, t_rsp - t_rise);
        end
        n_tests++;
        if (rsp_flags !== 4'b1000 || rsp_data !== 8'h00 || ENABLE !== 1'b1) begin
            n_fail++; $display("FAIL ack_timeout_rsp: flags=%b data=%h en=%b want 1000 00 1",
                               rsp_flags, rsp_data, ENABLE);
        end
        release_rsp();
    endtask

    task automatic test_hold_response();
        bit acc, ok; int br, bp, bad;
        m_drop = 1; m_delay = 4; m_busy = 8; m_dout = 8'hEE; m_flags = 3'b100;
        bp = pulses; bad = 0;
        send(3'd5, 8'h00, 17'd100, acc);
        await_rsp(200, ok, br);
        cmd_instr = 3'd2; cmd_data = 8'h5A; cmd_addr = 17'd7; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || rsp_flags !== 4'b0100 || rsp_data !== 8'h00 || cmd_ready !== 1'b0)
                bad++;
            step();
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (!ok || bad != 0) begin
            n_fail++; $display("FAIL hold_stable: rsp=%b unstable_cycles=%0d want 1 0", ok, bad);
        end
        n_tests++;
        if (rsp_flags !== 4'b0100) begin
            n_fail++; $display("FAIL hold_flags: got %b want 0100", rsp_flags);
        end
        release_rsp();
        repeat (4) step();
        n_tests++;
        if (pulses - bp != 1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_no_second_cmd: pulses=%0d rv=%b want 1 0", pulses - bp, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit acc, seen; int k, late;
        m_drop = 0;
        send(3'd2, 8'h33, 17'd9, acc);
        k = 0;
        while (ENABLE && k < 20) begin step(); k++; end
        n_tests++;
        if (ENABLE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_reach_pulse: en=%b want 0", ENABLE); end
        reset = 1'b1;
        step();
        n_tests++;
        if ({ENABLE, rsp_valid, cmd_ready} !== 3'b101) begin
            n_fail++; $display("FAIL mid_reset_outputs: en=%b rv=%b rdy=%b want 1 0 1", ENABLE, rsp_valid, cmd_ready);
        end
        reset = 1'b0;
        seen = 1'b0; late = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) seen = 1'b1;
            if (!ENABLE) late++;
            step();
        end
        n_tests++;
        if (seen || late != 0) begin
            n_fail++; $display("FAIL mid_reset_dropped: rsp_seen=%b low_after=%0d want 0 0", seen, late);
        end
    endtask

    task automatic test_random();
        bit acc, ok, fixed; int br, bp, bl, exp_lat, hold;
        logic [2:0] op; logic [7:0] d; logic [16:0] a;
        logic [7:0] exp_d; logic [3:0] exp_f;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            a  = 17'($urandom_range(0, 76799));
            fixed   = (op == 3'd0) || (op == 3'd7);
            m_drop  = !fixed && ($urandom_range(0, 5) != 0);
            m_delay = $urandom_range(1, 15);
            m_busy  = $urandom_range(1, 30);
            m_dout  = 8'($urandom);
            m_flags = 3'($urandom);
            hold    = $urandom_range(0, 5);
            if (fixed) begin
                exp_f = 4'b0000; exp_d = 8'h00; exp_lat = 8;
            end else if (!m_drop) begin
                exp_f = 4'b1000; exp_d = 8'h00; exp_lat = 64;
            end else begin
                exp_f = {1'b0, m_flags}; exp_d = (op == 3'd1) ? m_dout : 8'h00; exp_lat = -1;
            end
            bp = pulses; bl = low_cnt;
            send(op, d, a, acc);
            await_rsp(300, ok, br);
            n_tests++;
            if (!acc || !ok || pulses - bp != 1 || low_cnt - bl != 4) begin
                n_fail++; $display("FAIL rnd%0d_strobe: acc=%b rsp=%b pulses=%0d low=%0d want 1 1 1 4",
                                   n, acc, ok, pulses - bp, low_cnt - bl);
            end
            n_tests++;
            if ({p_instr, p_data, p_addr} !== {op, d, a}) begin
                n_fail++; $display("FAIL rnd%0d_operands: got %0d %h %0d want %0d %h %0d",
                                   n, p_instr, p_data, p_addr, op, d, a);
            end
            n_tests++;
            if (rsp_flags !== exp_f || rsp_data !== exp_d) begin
                n_fail++; $display("FAIL rnd%0d_rsp op=%0d: flags=%b data=%h want %b %h",
                                   n, op, rsp_flags, rsp_data, exp_f, exp_d);
            end
            if (exp_lat >= 0) begin
                n_tests++;
                if (t_rsp - t_rise != exp_lat) begin
                    n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, t_rsp - t_rise, exp_lat);
                end
            end
            repeat (hold) step();
            release_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_reset_inst();
        test_ack_timeout();
        test_hold_response();
        test_reset_mid_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
